// File: rtl/demap_pack_buffer_pkg.sv
// Shared definitions for the demapper/frame buffer feeding the Viterbi decoder.
// BASE_ADDR and the coded-byte default must match the decoder's addr_F reset and NOB.
package demap_pack_buffer_pkg;

   localparam logic [1:0] MOD_BPSK  = 2'd0;
   localparam logic [1:0] MOD_QPSK  = 2'd1;
   localparam logic [1:0] MOD_QAM16 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_READY,
      ST_HOLD
   } state_t;

   localparam int         DEF_CODED_BYTES = 30;
   localparam logic [5:0] DEF_BASE_ADDR   = 6'd1;

   // Reserved encoding 3 behaves as QPSK.
   function automatic logic [2:0] bits_per_symbol(input logic [1:0] mod);
      case (mod)
         MOD_BPSK:  bits_per_symbol = 3'd1;
         MOD_QAM16: bits_per_symbol = 3'd4;
         default:   bits_per_symbol = 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/demap_pack_buffer_hard_demapper.sv
// Combinational hard-decision demapper: one I/Q sample to 1, 2 or 4 coded bits, b0 in bit 0.
module hard_demapper
   import demap_pack_buffer_pkg::*;
#(
   parameter logic signed [15:0] QAM_THR = 16'sd2048
)(
   input  logic signed [15:0] yi,
   input  logic signed [15:0] yq,
   input  logic [1:0]         mod_sel,
   output logic [3:0]         bits,
   output logic [2:0]         nbits
);

   localparam logic signed [16:0] THR17 = {QAM_THR[15], QAM_THR};

   logic signed [16:0] yi_ext;
   logic signed [16:0] yq_ext;
   logic signed [16:0] abs_i;
   logic signed [16:0] abs_q;
   logic               i_inner;
   logic               q_inner;

   // Magnitudes are taken at 17 bits so that -32768 maps to +32768 instead of wrapping.
   always_comb begin
      yi_ext  = {yi[15], yi};
      yq_ext  = {yq[15], yq};
      abs_i   = yi_ext[16] ? -yi_ext : yi_ext;
      abs_q   = yq_ext[16] ? -yq_ext : yq_ext;
      i_inner = abs_i < THR17;
      q_inner = abs_q < THR17;
      nbits   = bits_per_symbol(mod_sel);
      case (mod_sel)
         MOD_BPSK:  bits = {3'b000, yi[15]};
         MOD_QAM16: bits = {q_inner, yq[15], i_inner, yi[15]};
         default:   bits = {2'b00, yq[15], yi[15]};
      endcase
   end

endmodule

// File: rtl/demap_pack_buffer.sv
// Demaps equalised symbols, packs coded bits LSB-first into bytes and buffers one frame
// for the Viterbi decoder, holding it until the decoder signals dec_done.
module demap_pack_buffer
   import demap_pack_buffer_pkg::*;
#(
   parameter int                 CODED_BYTES = DEF_CODED_BYTES,
   parameter logic signed [15:0] QAM_THR     = 16'sd2048,
   parameter logic [5:0]         BASE_ADDR   = DEF_BASE_ADDR
)(
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] yi,
   input  logic signed [15:0] yq,
   input  logic               sym_valid,
   input  logic [1:0]         mod_sel,
   input  logic [5:0]         addr_F,
   input  logic               dec_done,
   output logic signed [7:0]  demapped_out,
   output logic               start_decoder,
   output logic               buf_full,
   output logic               overflow
);

   localparam logic [5:0] LAST_COUNT = 6'(CODED_BYTES - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] mod_q;
   logic [1:0] mod_eff;
   logic [7:0] shift_q;
   logic [7:0] byte_next;
   logic [2:0] bit_pos;
   logic [3:0] pos_sum;
   logic [5:0] byte_cnt;
   logic [5:0] wr_addr;
   logic [3:0] sym_bits;
   logic [2:0] sym_nbits;
   logic       accept;
   logic       byte_done;
   logic       frame_done;
   logic       clear_frame;
   logic [7:0] mem [64];

   // The first symbol of a frame uses the live mod_sel; the rest use the latched copy.
   assign mod_eff = (state == ST_IDLE) ? mod_sel : mod_q;

   hard_demapper #(
      .QAM_THR (QAM_THR)
   ) u_demapper (
      .yi      (yi),
      .yq      (yq),
      .mod_sel (mod_eff),
      .bits    (sym_bits),
      .nbits   (sym_nbits)
   );

   always_comb begin
      accept     = sym_valid && ((state == ST_IDLE) || (state == ST_FILL));
      pos_sum    = {1'b0, bit_pos} + {1'b0, sym_nbits};
      byte_next  = shift_q | ({4'b0000, sym_bits} << bit_pos);
      byte_done  = accept && pos_sum[3];
      frame_done = byte_done && (byte_cnt == LAST_COUNT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      start_decoder = 1'b0;
      buf_full      = 1'b0;
      clear_frame   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sym_valid) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (frame_done) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            start_decoder = 1'b1;
            buf_full      = 1'b1;
            state_next    = ST_HOLD;
         end
         ST_HOLD: begin
            buf_full = 1'b1;
            if (dec_done) begin
               clear_frame = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Symbols arriving while the frame is held are dropped and flagged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mod_q    <= MOD_BPSK;
         shift_q  <= '0;
         bit_pos  <= '0;
         byte_cnt <= '0;
         wr_addr  <= BASE_ADDR;
         overflow <= 1'b0;
      end else begin
         if (sym_valid && ((state == ST_READY) || (state == ST_HOLD))) begin
            overflow <= 1'b1;
         end
         if (clear_frame) begin
            shift_q  <= '0;
            bit_pos  <= '0;
            byte_cnt <= '0;
            wr_addr  <= BASE_ADDR;
         end else if (accept) begin
            if (state == ST_IDLE) begin
               mod_q <= mod_sel;
            end
            if (byte_done) begin
               shift_q  <= '0;
               bit_pos  <= '0;
               byte_cnt <= byte_cnt + 6'd1;
               wr_addr  <= wr_addr + 6'd1;
            end else begin
               shift_q <= byte_next;
               bit_pos <= pos_sum[2:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (byte_done) begin
         mem[wr_addr] <= byte_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         demapped_out <= '0;
      end else begin
         demapped_out <= $signed(mem[addr_F]);
      end
   end

endmodule

// File: tb/tb_demap_pack_buffer.sv
// Self-checking bench for demap_pack_buffer: directed frames plus randomized frames
// compared against a bit-queue reference model.
module tb_demap_pack_buffer;
   import demap_pack_buffer_pkg::*;

   localparam int CB   = 30;
   localparam int BASE = 1;
   localparam int THR  = 2048;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] yi;
   logic signed [15:0] yq;
   logic               sym_valid;
   logic [1:0]         mod_sel;
   logic [5:0]         addr_F;
   logic               dec_done;
   logic signed [7:0]  demapped_out;
   logic               start_decoder;
   logic               buf_full;
   logic               overflow;

   always #5 clk = ~clk;

   demap_pack_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .yi            (yi),
      .yq            (yq),
      .sym_valid     (sym_valid),
      .mod_sel       (mod_sel),
      .addr_F        (addr_F),
      .dec_done      (dec_done),
      .demapped_out  (demapped_out),
      .start_decoder (start_decoder),
      .buf_full      (buf_full),
      .overflow      (overflow)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: the frame is a plain queue of coded bits; byte k is bits 8k..8k+7.
   bit         model_bits[$];
   logic [7:0] exp_mem [64];
   int         frame_mod;
   bit         m_full;
   bit         m_ready;
   bit         m_ovf;

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   function automatic int abs_int(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic void push_symbol(input int i, input int q);
      case (frame_mod)
         0: model_bits.push_back(i < 0);
         2: begin
            model_bits.push_back(i < 0);
            model_bits.push_back(abs_int(i) < THR);
            model_bits.push_back(q < 0);
            model_bits.push_back(abs_int(q) < THR);
         end
         default: begin
            model_bits.push_back(i < 0);
            model_bits.push_back(q < 0);
         end
      endcase
   endfunction

   function automatic void model_edge(input bit v, input int i, input int q, input int m, input bit done);
      int         k;
      logic [7:0] b;
      if (m_full) begin
         if (v) m_ovf = 1'b1;
         if (done && !m_ready) begin
            m_full = 1'b0;
            model_bits.delete();
         end
         m_ready = 1'b0;
      end else if (v) begin
         if (model_bits.size() == 0) frame_mod = (m == 0) ? 0 : ((m == 2) ? 2 : 1);
         push_symbol(i, q);
         if (model_bits.size() % 8 == 0) begin
            k = model_bits.size() / 8 - 1;
            for (int j = 0; j < 8; j++) b[j] = model_bits[8 * k + j];
            exp_mem[BASE + k] = b;
         end
         if (model_bits.size() == 8 * CB) begin
            m_full  = 1'b1;
            m_ready = 1'b1;
         end
      end
   endfunction

   task automatic apply_stimulus(input bit v, input int i, input int q, input int m, input bit done, input int addr);
      sym_valid = v;
      yi        = 16'(i);
      yq        = 16'(q);
      mod_sel   = 2'(m);
      dec_done  = done;
      addr_F    = 6'(addr);
      @(posedge clk);
      #1;
      model_edge(v, i, q, m, done);
      check_output("start_decoder", {7'd0, start_decoder}, {7'd0, m_ready});
      check_output("buf_full", {7'd0, buf_full}, {7'd0, m_full});
      check_output("overflow", {7'd0, overflow}, {7'd0, m_ovf});
   endtask

   task automatic check_buffer(input string tag);
      for (int a = BASE; a < BASE + CB; a++) begin
         apply_stimulus(1'b0, 0, 0, 0, 1'b0, a);
         check_output(tag, demapped_out, exp_mem[a]);
      end
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_bits.delete();
      m_full  = 1'b0;
      m_ready = 1'b0;
      m_ovf   = 1'b0;
      check_output("rst_demapped_out", demapped_out, 8'h00);
      check_output("rst_start", {7'd0, start_decoder}, 8'h00);
      check_output("rst_buf_full", {7'd0, buf_full}, 8'h00);
      check_output("rst_overflow", {7'd0, overflow}, 8'h00);
      sym_valid = 1'b0;
      dec_done  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic release_frame();
      apply_stimulus(1'b0, 0, 0, 0, 1'b1, 0);
   endtask

   function automatic int pick_sample();
      case ($urandom_range(0, 7))
         0: return -32768;
         1: return 32767;
         2: return 0;
         3: return THR;
         4: return -THR;
         5: return THR - 1;
         6: return -(THR - 1);
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   initial begin
      reset     = 1'b1;
      sym_valid = 1'b0;
      yi        = '0;
      yq        = '0;
      mod_sel   = '0;
      addr_F    = '0;
      dec_done  = 1'b0;
      frame_mod = 0;
      m_full    = 1'b0;
      m_ready   = 1'b0;
      m_ovf     = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      $display("[TB] QPSK alternating frame");
      for (int n = 0; n < 120; n++) begin
         apply_stimulus(1'b1, (n % 2) ? 100 : -100, (n % 2) ? -100 : 100, 1, 1'b0, 1);
      end
      check_buffer("qpsk_buf");
      apply_stimulus(1'b0, 0, 0, 0, 1'b0, 30);
      check_output("qpsk_byte30", demapped_out, 8'h99);

      $display("[TB] symbols while holding");
      for (int n = 0; n < 5; n++) apply_stimulus(1'b1, -5000, -5000, 2, 1'b0, 0);
      check_buffer("hold_buf");
      apply_stimulus(1'b1, -100, 100, 1, 1'b1, 0);

      $display("[TB] BPSK zero and minus-one frames");
      for (int n = 0; n < 240; n++) apply_stimulus(1'b1, 0, -7, 0, 1'b0, 0);
      check_buffer("bpsk0_buf");
      apply_stimulus(1'b0, 0, 0, 0, 1'b0, 1);
      check_output("bpsk0_byte1", demapped_out, 8'h00);
      release_frame();
      for (int n = 0; n < 240; n++) apply_stimulus(1'b1, -1, 5, 0, 1'b0, 0);
      check_buffer("bpskm1_buf");
      apply_stimulus(1'b0, 0, 0, 0, 1'b0, 1);
      check_output("bpskm1_byte1", demapped_out, 8'hFF);
      release_frame();

      $display("[TB] 16QAM frames");
      for (int n = 0; n < 60; n++) apply_stimulus(1'b1, -1000, 3000, 2, 1'b0, 0);
      check_buffer("qam_buf");
      apply_stimulus(1'b0, 0, 0, 0, 1'b0, 15);
      check_output("qam_byte15", demapped_out, 8'h33);
      release_frame();
      for (int n = 0; n < 60; n++) apply_stimulus(1'b1, pick_sample(), pick_sample(), 2, 1'b0, 0);
      check_buffer("qam_edge_buf");
      release_frame();

      $display("[TB] mod_sel change inside a frame");
      for (int n = 0; n < 120; n++) begin
         apply_stimulus(1'b1, pick_sample(), pick_sample(), (n < 3) ? 1 : 0, 1'b0, 0);
      end
      check_buffer("modlatch_buf");
      release_frame();

      $display("[TB] reset in the middle of a frame");
      for (int n = 0; n < 50; n++) apply_stimulus(1'b1, (n % 2) ? 100 : -100, (n % 2) ? -100 : 100, 1, 1'b0, 1);
      do_reset();
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 3) == 0) apply_stimulus(1'b0, 0, 0, 1, 1'b0, 0);
         apply_stimulus(1'b1, pick_sample(), pick_sample(), 1, 1'b0, 0);
      end
      check_buffer("postrst_buf");
      release_frame();

      $display("[TB] randomized frames");
      for (int f = 0; f < 4; f++) begin
         int cyc = 0;
         while (!m_full && cyc < 2000) begin
            apply_stimulus($urandom_range(0, 3) != 0, pick_sample(), pick_sample(),
                           int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                           int'($urandom_range(0, 63)));
            cyc++;
         end
         apply_stimulus(1'b0, 0, 0, 0, 1'b1, 0);
         check_buffer("rand_buf");
         for (int n = 0; n < 3; n++) apply_stimulus($urandom_range(0, 1) == 1, pick_sample(), 0, 1, 1'b0, 0);
         release_frame();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
